// File: rtl/alarm_sensor_encoder.sv
`default_nettype none
// ============================================================================
// Module   : alarm_sensor_encoder
// Purpose  : Thresholds, debounces and latches fire/burglar/rain sensors into a
//            3-bit alarm state vector with a registered change strobe.
//            Optional macro FIRE_LATCH_EN latches fire until acknowledged.
// Revision : 1.0 - initial release
// ============================================================================
module alarm_sensor_encoder #(
  parameter int TEMP_W     = 8,
  parameter int FIRE_TEMP  = 60,
  parameter int RAIN_LEVEL = 40,
  parameter int DEB_ON     = 4,
  parameter int DEB_OFF    = 8,
  parameter int CNT_W      = 4
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [TEMP_W-1:0] temp,
  input  logic              smoke,
  input  logic              motion,
  input  logic              door_open,
  input  logic              armed,
  input  logic [TEMP_W-1:0] rain_level,
  input  logic              fire_ack,
  output logic [2:0]        state,
  output logic              state_chg
);

  localparam int c_fire = 2;
  localparam int c_burg = 1;
  localparam int c_rain = 0;

  localparam logic [TEMP_W-1:0] c_fire_thr = TEMP_W'(FIRE_TEMP);
  localparam logic [TEMP_W-1:0] c_rain_thr = TEMP_W'(RAIN_LEVEL);
  localparam logic [CNT_W-1:0]  c_on_last  = CNT_W'(DEB_ON - 1);
  localparam logic [CNT_W-1:0]  c_off_last = CNT_W'(DEB_OFF - 1);

  logic [2:0]       w_raw;
  logic [2:0]       w_b_nxt;
  logic [2:0]       r_b;
  logic [CNT_W-1:0] w_cnt_nxt [3];
  logic [CNT_W-1:0] r_cnt     [3];
  logic             r_state_chg;

  always_comb begin
    w_raw         = '0;
    w_raw[c_fire] = smoke | (temp >= c_fire_thr);
    w_raw[c_burg] = armed & (motion | door_open);
    w_raw[c_rain] = (rain_level >= c_rain_thr);
  end

  always_comb begin
    for (int i = 0; i < 3; i++) begin
      w_b_nxt[i]   = r_b[i];
      w_cnt_nxt[i] = '0;
      if (w_raw[i] != r_b[i]) begin
        if (r_cnt[i] == (r_b[i] ? c_off_last : c_on_last)) begin
          w_b_nxt[i] = ~r_b[i];
        end else begin
          w_cnt_nxt[i] = r_cnt[i] + 1'b1;
        end
      end
    end

    // Burglar latches while armed; disarming overrides any pending set.
    if (!armed) begin
      w_b_nxt[c_burg]   = 1'b0;
      w_cnt_nxt[c_burg] = '0;
    end else if (r_b[c_burg]) begin
      w_b_nxt[c_burg]   = 1'b1;
      w_cnt_nxt[c_burg] = '0;
    end

`ifdef FIRE_LATCH_EN
    if (r_b[c_fire]) begin
      w_b_nxt[c_fire]   = ~(fire_ack & ~w_raw[c_fire]);
      w_cnt_nxt[c_fire] = '0;
    end
`endif
  end

`ifndef FIRE_LATCH_EN
  logic w_unused_fire_ack;
  assign w_unused_fire_ack = fire_ack;
`endif

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_b         <= '0;
      r_state_chg <= 1'b0;
      for (int i = 0; i < 3; i++) r_cnt[i] <= '0;
    end else begin
      r_b         <= w_b_nxt;
      r_state_chg <= (w_b_nxt != r_b);
      for (int i = 0; i < 3; i++) r_cnt[i] <= w_cnt_nxt[i];
    end
  end

  assign state     = r_b;
  assign state_chg = r_state_chg;

endmodule
`default_nettype wire
